// File: rtl/key_rel_det_pkg.sv
// Shared types and default timing constants for the key release detector.
package key_pkg;

    // Press lifecycle states; 3-bit encoding leaves two unused codes.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PDEB   = 3'd1,
        HELD   = 3'd2,
        LONG   = 3'd3,
        RDEB_S = 3'd4,
        RDEB_L = 3'd5
    } key_st_e;

    localparam int KEY_DEB  = 50;
    localparam int KEY_LONG = 1000;
    localparam int KEY_REP  = 200;
    localparam int KEY_CW   = 11;

endpackage

// File: rtl/key_rel_det_if.sv
// Button-side signal bundle: raw button in, debounced level and event pulses out.
interface key_rel_det_if;
    logic BTN;
    logic PRS;
    logic LNG;
    logic REP;
    logic REL;
    logic LREL;

    modport master (output BTN, input PRS, LNG, REP, REL, LREL);
    modport slave  (input BTN, output PRS, LNG, REP, REL, LREL);
endinterface

// File: rtl/key_rel_det_tmr.sv
// Shared phase timer: clear, load-one, increment, and terminal compare against lim-1.
module key_tmr #(
    parameter int CW = 11
) (
    input  logic          C1K,
    input  logic          RST,
    input  logic          clr,
    input  logic          ld1,
    input  logic          inc,
    input  logic [CW-1:0] lim,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    // Terminal count is combinational so the FSM can act on the same edge.
    assign tc = (cnt == lim - CW'(1));

    // Counter update; clr wins over ld1, ld1 over inc.
    always_ff @(posedge C1K or negedge RST) begin
        if (!RST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (ld1)
            cnt <= CW'(1);
        else if (inc)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/key_rel_det.sv
// Debounced push-button lifecycle tracker: press level, long press, auto-repeat,
// and separate short/long release pulses.
module key_rel_det
    import key_pkg::*;
#(
    parameter int DEB    = KEY_DEB,
    parameter int LONG_T = KEY_LONG,
    parameter int REP_T  = KEY_REP,
    parameter int CW     = KEY_CW
) (
    input  logic          C1K,
    input  logic          RST,
    key_rel_det_if.slave  bus
);

    key_st_e       state;
    logic          prs_q, lng_q, rep_q, rel_q, lrel_q;
    logic          t_clr, t_ld1, t_inc, t_tc;
    logic [CW-1:0] t_lim, t_cnt;
    logic          btn;

    assign btn = bus.BTN;

    // Timer limit follows the phase being timed.
    always_comb begin
        t_lim = CW'(DEB);
        case (state)
            HELD:    t_lim = CW'(LONG_T);
            LONG:    t_lim = CW'(REP_T);
            default: t_lim = CW'(DEB);
        endcase
    end

    // Timer control mirrors the FSM transitions: every transition either
    // clears or loads 1, otherwise the current phase keeps counting.
    always_comb begin
        t_clr = 1'b0;
        t_ld1 = 1'b0;
        t_inc = 1'b0;
        case (state)
            IDLE: begin
                if (btn) t_ld1 = 1'b1;
                else     t_clr = 1'b1;
            end
            PDEB: begin
                if (!btn || t_tc) t_clr = 1'b1;
                else              t_inc = 1'b1;
            end
            HELD, LONG: begin
                if (!btn)      t_ld1 = 1'b1;
                else if (t_tc) t_clr = 1'b1;
                else           t_inc = 1'b1;
            end
            RDEB_S, RDEB_L: begin
                if (btn || t_tc) t_clr = 1'b1;
                else             t_inc = 1'b1;
            end
            default: t_clr = 1'b1;
        endcase
    end

    key_tmr #(.CW(CW)) u_tmr (
        .C1K (C1K),
        .RST (RST),
        .clr (t_clr),
        .ld1 (t_ld1),
        .inc (t_inc),
        .lim (t_lim),
        .cnt (t_cnt),
        .tc  (t_tc)
    );

    // State machine with registered level and one-cycle event pulses.
    always_ff @(posedge C1K or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            prs_q  <= 1'b0;
            lng_q  <= 1'b0;
            rep_q  <= 1'b0;
            rel_q  <= 1'b0;
            lrel_q <= 1'b0;
        end else begin
            lng_q  <= 1'b0;
            rep_q  <= 1'b0;
            rel_q  <= 1'b0;
            lrel_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn) state <= PDEB;
                end
                PDEB: begin
                    if (!btn) begin
                        state <= IDLE;
                    end else if (t_tc) begin
                        state <= HELD;
                        prs_q <= 1'b1;
                    end
                end
                HELD: begin
                    if (!btn) begin
                        state <= RDEB_S;
                    end else if (t_tc) begin
                        state <= LONG;
                        lng_q <= 1'b1;
                    end
                end
                LONG: begin
                    if (!btn)      state <= RDEB_L;
                    else if (t_tc) rep_q <= 1'b1;
                end
                RDEB_S: begin
                    if (btn) begin
                        state <= HELD;
                    end else if (t_tc) begin
                        state <= IDLE;
                        prs_q <= 1'b0;
                        rel_q <= 1'b1;
                    end
                end
                RDEB_L: begin
                    if (btn) begin
                        state <= LONG;
                    end else if (t_tc) begin
                        state  <= IDLE;
                        prs_q  <= 1'b0;
                        lrel_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    prs_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PRS  = prs_q;
    assign bus.LNG  = lng_q;
    assign bus.REP  = rep_q;
    assign bus.REL  = rel_q;
    assign bus.LREL = lrel_q;

endmodule

// File: doc/key_rel_det.md
Name: key_rel_det

Overview:
- Release-side companion to the key-on press detector.
- Debounces a raw push-button and tracks the whole press lifecycle: debounced press level, long-press detection, auto-repeat while held, and a debounced release event.
- Release is reported separately for short and long presses.
- Sits between the raw board button input (C1K domain, 1 kHz tick) and application FSMs. Replaces ad-hoc release logic in each consumer.

Parameters:
- DEB, 50, consecutive C1K edges BTN must be stable to accept a press or a release (>= 2)
- LONG_T, 1000, C1K edges in HELD, after press acceptance, before a long press is declared (>= 2)
- REP_T, 200, C1K edges between auto-repeat pulses in LONG (>= 2)
- CW, 11, timer width; must satisfy 2^CW > max(DEB, LONG_T, REP_T)

Ports:
- C1K  input  1  system tick clock, rising edge
- RST  input  1  reset, asynchronous, active-low
- BTN  input  1  raw button, 1 = pressed; already synchronised upstream
- PRS  output 1  debounced press level
- LNG  output 1  one-cycle pulse: long press reached
- REP  output 1  one-cycle pulse: auto-repeat tick
- REL  output 1  one-cycle pulse: debounced release of a short press
- LREL output 1  one-cycle pulse: debounced release of a long press

Behaviour:
- Reset:
  - Asynchronous, active-low RST forces state IDLE and cnt=0.
  - All outputs are forced to 0 immediately, with no clock edge needed.
  - Reset mid-press discards all history. After RST deasserts with BTN already high, a full DEB debounce is required before PRS rises.
- Output timing:
  - All outputs are registers updated on the same edge as the state and cnt update.
  - Each pulse is high for exactly one C1K cycle.
- States (cnt = CW-bit timer, updated every edge):
  - IDLE: BTN=1 -> PDEB, cnt=1. Otherwise stay, cnt=0.
  - PDEB: BTN=0 -> IDLE, cnt=0, no output (glitch rejected). BTN=1 and cnt==DEB-1 -> HELD, cnt=0, PRS<=1. Otherwise cnt+1.
  - HELD: BTN=0 -> RDEB_S, cnt=1. BTN=1 and cnt==LONG_T-1 -> LONG, cnt=0, LNG pulse. Otherwise cnt+1.
  - LONG: BTN=0 -> RDEB_L, cnt=1. BTN=1 and cnt==REP_T-1 -> stay, cnt=0, REP pulse. Otherwise cnt+1.
  - RDEB_S: BTN=1 -> HELD, cnt=0 (long timer restarts). BTN=0 and cnt==DEB-1 -> IDLE, cnt=0, PRS<=0, REL pulse. Otherwise cnt+1.
  - RDEB_L: BTN=1 -> LONG, cnt=0 (repeat timer restarts). BTN=0 and cnt==DEB-1 -> IDLE, cnt=0, PRS<=0, LREL pulse. Otherwise cnt+1.
- PRS level:
  - 1 in HELD, LONG, RDEB_S and RDEB_L.
  - 0 in IDLE and PDEB.
  - PRS therefore stays high during release debounce.
- Latency with BTN held high from edge 1:
  - PRS rises after edge DEB.
  - LNG pulses after edge DEB+LONG_T.
  - REP pulses after edges DEB+LONG_T+k*REP_T, k >= 1.
- Release latency: REL or LREL pulses, and PRS falls, after the DEB-th consecutive edge with BTN=0.
- Exclusivity:
  - At most one of LNG, REP, REL, LREL is high in any cycle.
  - No REP pulse occurs in the same cycle as LNG.
  - Exactly one REL or LREL occurs per accepted press.
- cnt never exceeds max(DEB, LONG_T, REP_T)-1, so no wrap-around is possible.
- Unreachable state encodings -> IDLE, cnt=0 on the next edge.

Decomposition:
- Package key_pkg holds:
  - the state enum (IDLE, PDEB, HELD, LONG, RDEB_S, RDEB_L) with a 3-bit encoding;
  - default constants KEY_DEB=50, KEY_LONG=1000, KEY_REP=200, KEY_CW=11.
- One sub-module, key_tmr: CW-bit counter with synchronous clr, ld1, inc and a terminal compare (cnt==lim-1) output. Uses the same RST.
- The FSM and output registers stay in key_rel_det.

Test Plan (DEB=4, LONG_T=20, REP_T=8, CW=5):
- Short press: BTN=1 for 10 edges then 0 -> PRS rises after edge 4. REL pulses once after edge 14 (4th low edge) and PRS falls with it. LNG, REP and LREL stay 0.
- Glitch rejection: BTN=1 for 3 edges, 0 for 3, 1 for 2, then 0 -> PRS and all pulses remain 0 throughout; state back in IDLE.
- Long press with repeat: BTN=1 for 50 edges then 0 -> LNG after edge 24, REP after edges 32, 40 and 48, LREL after edge 54 (4th low edge). REL is never asserted.
- Release bounce: in HELD, BTN=0 for 2 edges then 1 again -> PRS stays 1 and no REL. The long timer restarts, so LNG comes 20 edges after the bounce ends.
- Reset mid-press: assert RST in LONG between edges -> all outputs 0 immediately. Release RST with BTN=1 -> PRS rises 4 edges later and LNG 20 edges after that; no LREL from the aborted press.
